// File: rtl/spi_frame_master.sv
// Full-duplex SPI master: each word is sent as N_FRAMES chip-select frames of
// FRAME_W bits, MSB first, with a programmable SCLK divider and inter-frame gap.
module spi_frame_master #(
  parameter int unsigned FRAME_W   = 16,
  parameter int unsigned N_FRAMES  = 2,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned PAUSE_CYC = 4,
  parameter int unsigned CPOL      = 0,
  parameter int unsigned CPHA      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [FRAME_W*N_FRAMES-1:0]   tx_data,
  output logic                          busy,
  output logic                          done,
  output logic [FRAME_W*N_FRAMES-1:0]   rx_data,
  output logic                          sclk,
  output logic                          csn,
  output logic                          mosi,
  input  logic                          miso
);

  localparam int unsigned WORD_W  = FRAME_W * N_FRAMES;
  localparam int unsigned HALVES  = 2 * FRAME_W;
  localparam int unsigned HALF_W  = $clog2(HALVES);
  localparam int unsigned CNT_MAX = (CLK_DIV > PAUSE_CYC) ? CLK_DIV : PAUSE_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned FRM_W   = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam logic        POL     = 1'(CPOL);
  localparam logic        PHA0    = (CPHA == 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_XFER, S_HOLD, S_PAUSE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [FRM_W-1:0]    frame_q, frame_d;
  logic [WORD_W-1:0]   tx_q, tx_d;
  logic [WORD_W-1:0]   rxs_q, rxs_d;
  logic [WORD_W-1:0]   rx_data_q, rx_data_d;
  logic                sclk_q, sclk_d;
  logic                csn_q, csn_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                edge_c;
  logic                lead_c;
  logic [HALF_W-1:0]   nhalf_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      frame_q   <= '0;
      tx_q      <= '0;
      rxs_q     <= '0;
      rx_data_q <= '0;
      sclk_q    <= POL;
      csn_q     <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      frame_q   <= frame_d;
      tx_q      <= tx_d;
      rxs_q     <= rxs_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      csn_q     <= csn_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; outputs are computed for the next cycle and registered
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    half_d    = half_q;
    frame_d   = frame_q;
    tx_d      = tx_q;
    rxs_d     = rxs_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    csn_d     = 1'b1;
    busy_d    = 1'b0;
    edge_c    = 1'b0;
    lead_c    = 1'b0;
    nhalf_c   = half_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_SETUP;
          tx_d    = tx_data;
          frame_d = '0;
          mosi_d  = PHA0 ? tx_data[WORD_W-1] : 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = S_XFER;
          cnt_d   = '0;
          edge_c  = 1'b1;
          nhalf_c = '0;
        end
      end
      S_XFER: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (half_q == HALF_W'(HALVES - 1)) begin
            state_d = S_HOLD;
          end else begin
            edge_c  = 1'b1;
            nhalf_c = half_q + HALF_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (frame_q == FRM_W'(N_FRAMES - 1)) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            rx_data_d = rxs_q;
          end else begin
            state_d = S_PAUSE;
            frame_d = frame_q + FRM_W'(1);
          end
        end
      end
      S_PAUSE: begin
        if (cnt_q == CNT_W'(PAUSE_CYC - 1)) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          mosi_d  = PHA0 ? tx_q[WORD_W-1] : 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Each new half-period starts with an SCLK edge; even halves are leading edges
    if (edge_c) begin
      half_d = nhalf_c;
      lead_c = ~nhalf_c[0];
      sclk_d = lead_c ? ~POL : POL;
      if (lead_c == PHA0) begin
        rxs_d = {rxs_q[WORD_W-2:0], miso};
      end
      if (PHA0 && !lead_c) begin
        tx_d = tx_q << 1;
        if (nhalf_c != HALF_W'(HALVES - 1)) begin
          mosi_d = tx_q[WORD_W-2];
        end
      end
      if (!PHA0 && lead_c) begin
        mosi_d = tx_q[WORD_W-1];
        tx_d   = tx_q << 1;
      end
    end

    // Chip-select, busy and idle levels follow the next state
    if (state_d == S_SETUP || state_d == S_XFER || state_d == S_HOLD) begin
      csn_d = 1'b0;
    end else begin
      mosi_d = 1'b0;
    end
    if (state_d != S_XFER) begin
      sclk_d = POL;
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign csn     = csn_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: default mode-0 device with a slave model,
// four loopback instances (one per SPI mode) and a single-frame mode-3 instance.
module tb_spi_frame_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] start_v = '0;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // ---------------- default instance with mode-0 slave ----------------
  logic [31:0] tx0 = '0;
  logic [31:0] srv0 = '0;
  wire  [31:0] rx0;
  wire  busy0, done0, sclk0, csn0, mosi0;
  logic miso0;
  logic clr0 = 1'b0;
  int   bc0;
  logic [4:0] sidx0;
  logic [31:0] srx0;

  spi_frame_master u_d0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .tx_data(tx0),
    .busy(busy0), .done(done0), .rx_data(rx0),
    .sclk(sclk0), .csn(csn0), .mosi(mosi0), .miso(miso0)
  );

  // Mode-0 slave: next bit after each falling SCLK, captures mosi on rising SCLK
  always @(negedge sclk0 or posedge clr0) begin
    if (clr0) bc0 <= 0;
    else if (!csn0) bc0 <= bc0 + 1;
  end
  assign sidx0 = 5'(31 - bc0);
  assign miso0 = (bc0 < 32) ? srv0[sidx0] : 1'b0;
  always @(posedge sclk0) if (!csn0) srx0 <= {srx0[30:0], mosi0};

  int rise0 = 0;
  int gap0  = 0;
  int dcnt0 = 0;
  always @(posedge sclk0) if (!csn0) rise0++;
  always @(negedge clk) if (busy0 && csn0) gap0++;
  always @(posedge clk) if (done0) dcnt0++;

  // ---------------- loopback instances, one per mode ----------------
  logic [31:0] lb_tx = '0;
  wire  [3:0]  lb_busy, lb_done, lb_sclk, lb_csn, lb_mosi;
  wire  [31:0] lb_rx [4];

  for (genvar m = 0; m < 4; m++) begin : g_lb
    spi_frame_master #(.CLK_DIV(3), .CPOL(m / 2), .CPHA(m % 2)) u_dut (
      .clk(clk), .rst(rst), .start(start_v[1+m]), .tx_data(lb_tx),
      .busy(lb_busy[m]), .done(lb_done[m]), .rx_data(lb_rx[m]),
      .sclk(lb_sclk[m]), .csn(lb_csn[m]), .mosi(lb_mosi[m]), .miso(lb_mosi[m])
    );
  end

  // ---------------- 8-bit single-frame mode-3 instance ----------------
  logic [7:0] tx8 = '0;
  logic [7:0] srv8 = '0;
  wire  [7:0] rx8;
  wire  busy8, done8, sclk8, csn8, mosi8;
  logic miso8;
  logic clr8 = 1'b0;
  int   bc8;
  logic [2:0] sidx8;

  spi_frame_master #(.FRAME_W(8), .N_FRAMES(1), .CLK_DIV(2), .CPOL(1), .CPHA(1)) u_d8 (
    .clk(clk), .rst(rst), .start(start_v[5]), .tx_data(tx8),
    .busy(busy8), .done(done8), .rx_data(rx8),
    .sclk(sclk8), .csn(csn8), .mosi(mosi8), .miso(miso8)
  );

  // Mode-3 slave: drives the next bit on each leading (falling) SCLK edge
  always @(negedge sclk8 or posedge clr8) begin
    if (clr8) bc8 <= 0;
    else if (!csn8) bc8 <= bc8 + 1;
  end
  assign sidx8 = 3'(8 - bc8);
  assign miso8 = (bc8 >= 1 && bc8 <= 8) ? srv8[sidx8] : 1'b0;

  wire [5:0] done_all = {done8, lb_done, done0};

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Raise start for one sampling edge; returns #1 after that edge
  task automatic do_start(input int idx);
    start_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_v[idx] = 1'b0;
  endtask

  // Count edges until done is seen; an expired bound leaves lat at the limit
  task automatic wait_done(input int idx, output int lat);
    lat = 0;
    while (lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_all[idx]) break;
    end
  endtask

  task automatic clear_slaves();
    clr0 = 1'b1; clr8 = 1'b1;
    #1;
    clr0 = 1'b0; clr8 = 1'b0;
  endtask

  int lat, lat2, r_snap, g_snap, d_snap;

  initial begin
    clear_slaves();
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_csn",  64'(csn0),  64'h1);
    check("rst_sclk", 64'(sclk0), 64'h0);
    check("rst_mosi", 64'(mosi0), 64'h0);
    check("rst_busy", 64'(busy0), 64'h0);
    check("rst_done", 64'(done0), 64'h0);
    check("rst_rx",   64'(rx0),   64'h0);
    check("rst_sclk8", 64'(sclk8), 64'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Default word, mode 0: slave serves DEADBEEF, T = 72
    srv0 = 32'hDEADBEEF; tx0 = 32'h13579BDF;
    clear_slaves();
    r_snap = rise0; g_snap = gap0;
    do_start(0);
    check("start_csn", 64'(csn0), 64'h0);
    check("start_busy", 64'(busy0), 64'h1);
    wait_done(0, lat);
    check("def_lat", 64'(lat), 64'd72);
    check("def_rx", 64'(rx0), 64'hDEADBEEF);
    check("def_busy_in_done", 64'(busy0), 64'h0);
    check("def_rises", 64'(rise0 - r_snap), 64'd32);
    check("def_gap", 64'(gap0 - g_snap), 64'd4);
    check("def_slave_rx", 64'(srx0), 64'h13579BDF);

    // Back-to-back: start in the cycle after done
    srv0 = 32'h12345678; tx0 = 32'h0000FFFF;
    clear_slaves();
    @(posedge clk);
    #1;
    check("b2b_idle_hold", 64'(rx0), 64'hDEADBEEF);
    do_start(0);
    repeat (36) @(posedge clk);
    #1;
    check("b2b_mid_hold", 64'(rx0), 64'hDEADBEEF);
    wait_done(0, lat2);
    check("b2b_lat", 64'(36 + lat2), 64'd72);
    check("b2b_rx", 64'(rx0), 64'h12345678);
    check("b2b_slave_rx", 64'(srx0), 64'h0000FFFF);

    // start held for the whole word and through the DONE cycle
    repeat (2) @(posedge clk);
    #1;
    srv0 = 32'hCAFEF00D;
    clear_slaves();
    d_snap = dcnt0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    wait_done(0, lat);
    check("hold_lat", 64'(lat), 64'd72);
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("hold_one_done", 64'(dcnt0 - d_snap), 64'd1);
    check("hold_idle_busy", 64'(busy0), 64'h0);
    check("hold_idle_csn", 64'(csn0), 64'h1);
    check("hold_rx", 64'(rx0), 64'hCAFEF00D);

    // Reset during frame 2, around bit 5
    clear_slaves();
    d_snap = dcnt0;
    do_start(0);
    repeat (48) @(posedge clk);
    #1;
    check("mid_in_word", 64'({busy0, csn0}), 64'h2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_csn",  64'(csn0),  64'h1);
    check("abort_sclk", 64'(sclk0), 64'h0);
    check("abort_busy", 64'(busy0), 64'h0);
    check("abort_mosi", 64'(mosi0), 64'h0);
    check("abort_rx",   64'(rx0),   64'h0);
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_done", 64'(dcnt0 - d_snap), 64'd0);

    // Normal word after the abort
    srv0 = 32'h0F1E2D3C;
    clear_slaves();
    do_start(0);
    wait_done(0, lat);
    check("post_lat", 64'(lat), 64'd72);
    check("post_rx", 64'(rx0), 64'h0F1E2D3C);

    // Loopback in all four modes, CLK_DIV=3: T = 2*34*3 + 4 = 208
    lb_tx = 32'hA5C31E77;
    for (int m = 0; m < 4; m++) begin
      check($sformatf("lb%0d_idle_pre", m), 64'(lb_sclk[m]), 64'(m / 2));
      do_start(1 + m);
      wait_done(1 + m, lat);
      check($sformatf("lb%0d_lat", m), 64'(lat), 64'd208);
      check($sformatf("lb%0d_rx", m), 64'(lb_rx[m]), 64'hA5C31E77);
      @(posedge clk);
      #1;
      check($sformatf("lb%0d_idle_post", m), 64'(lb_sclk[m]), 64'(m / 2));
    end

    // 8-bit mode-3 single frame, CLK_DIV=2: T = 18*2 = 36
    srv8 = 8'h3C; tx8 = 8'h81;
    clear_slaves();
    g_snap = gap0;
    do_start(5);
    wait_done(5, lat);
    check("m3_lat", 64'(lat), 64'd36);
    check("m3_rx", 64'(rx8), 64'h3C);
    check("m3_csn_done", 64'(csn8), 64'h1);
    @(posedge clk);
    #1;
    check("m3_sclk_idle", 64'(sclk8), 64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
